// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;
  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE} arb_state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} arb_owner_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, data port, memory-side handshake and stall outputs.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_f;
  logic              stall_m;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    output if_rdata, if_valid, dm_rdata, dm_valid,
           mem_req, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    input  if_rdata, if_valid, dm_rdata, dm_valid,
           mem_req, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );
endinterface

// File: rtl/mem_arb_streak_ctr.sv
// Saturating count of consecutive data grants made while fetch was waiting.
module mem_arb_streak_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  logic [STREAK_W-1:0] count_reg;

  assign at_max = (count_reg == STREAK_W'(MAX_STREAK));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && !at_max) begin
      count_reg <= count_reg + 1'b1;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data-port accesses onto one single-ported memory,
// one outstanding transaction at a time, with a bounded data-priority streak.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.master bus
);
  arb_state_t        state_reg, state_next;
  arb_owner_t        owner_reg, owner_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] if_rdata_reg, dm_rdata_reg;
  logic              if_valid_reg, dm_valid_reg;
  logic              streak_inc, streak_clr, streak_at_max;
  logic              capture;

  mem_arb_streak_ctr #(.MAX_STREAK(MAX_STREAK)) u_streak (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (streak_inc),
    .clr    (streak_clr),
    .at_max (streak_at_max)
  );

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    streak_inc = 1'b0;
    streak_clr = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        // Data normally wins; fetch is forced through once the streak saturates.
        if (bus.dm_req && !(bus.if_req && streak_at_max)) begin
          state_next = ARB_ISSUE;
          owner_next = OWN_DATA;
          we_next    = bus.dm_we;
          addr_next  = bus.dm_addr;
          wdata_next = bus.dm_wdata;
          streak_inc = bus.if_req;
          streak_clr = !bus.if_req;
        end else if (bus.if_req) begin
          state_next = ARB_ISSUE;
          owner_next = OWN_FETCH;
          we_next    = 1'b0;
          addr_next  = bus.if_addr;
          wdata_next = '0;
          streak_clr = 1'b1;
        end else begin
          streak_clr = 1'b1;
        end
      end
      ARB_ISSUE: if (bus.mem_ready)  state_next = ARB_WAIT;
      ARB_WAIT:  if (bus.mem_rvalid) state_next = ARB_DONE;
      ARB_DONE:  state_next = ARB_IDLE;
      default:   state_next = ARB_IDLE;
    endcase
  end

  assign capture = (state_reg == ARB_WAIT) && bus.mem_rvalid && !we_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ARB_IDLE;
      owner_reg    <= OWN_FETCH;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      if_rdata_reg <= '0;
      dm_rdata_reg <= '0;
      if_valid_reg <= 1'b0;
      dm_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      if (capture && owner_reg == OWN_DATA)  dm_rdata_reg <= bus.mem_rdata;
      if (capture && owner_reg == OWN_FETCH) if_rdata_reg <= bus.mem_rdata;
      // The completion pulse is registered out of DONE, landing one cycle later.
      if_valid_reg <= (state_reg == ARB_DONE) && (owner_reg == OWN_FETCH);
      dm_valid_reg <= (state_reg == ARB_DONE) && (owner_reg == OWN_DATA);
    end
  end

  assign bus.mem_req   = (state_reg == ARB_ISSUE);
  assign bus.mem_we    = we_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.dm_rdata  = dm_rdata_reg;
  assign bus.if_valid  = if_valid_reg;
  assign bus.dm_valid  = dm_valid_reg;
  assign bus.stall_f   = bus.if_req & ~if_valid_reg;
  assign bus.stall_m   = bus.dm_req & ~dm_valid_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory responder.
module tb_mem_arbiter;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  bit          mem_auto = 1'b1;
  int          ready_delay = 0;
  int          wait_cnt = 0;
  bit          acc_pend = 1'b0;
  logic [31:0] acc_addr = '0;
  logic [31:0] grants[$];

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic mem_model();
    bus.mem_rvalid = 1'b0;
    if (acc_pend) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mem_word(acc_addr);
      acc_pend       = 1'b0;
    end
    bus.mem_ready = 1'b0;
    if (bus.mem_req) begin
      if (wait_cnt >= ready_delay) begin
        bus.mem_ready = 1'b1;
        acc_pend      = 1'b1;
        acc_addr      = bus.mem_addr;
        wait_cnt      = 0;
        grants.push_back(bus.mem_addr);
        $display("txn cyc=%0d addr=%h we=%0b wdata=%h", cyc, bus.mem_addr, bus.mem_we, bus.mem_wdata);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (mem_auto) mem_model();
  endtask

  task automatic wait_valid(input bit data_side, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (data_side ? bus.dm_valid : bus.if_valid) seen = 1'b1;
    end
    check(tag, seen, 1'b1);
  endtask

  initial begin
    int          f_issue;
    int          dv_cyc;
    bit          done;
    logic [31:0] g;
    logic [31:0] exp_order[6];

    rst_n = 1'b0;
    bus.if_req = 0; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;

    // Reset state
    step(); step();
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_if_valid", bus.if_valid, 1'b0);
    check("rst_dm_valid", bus.dm_valid, 1'b0);
    check("rst_if_rdata", bus.if_rdata, 32'h0);
    check("rst_dm_rdata", bus.dm_rdata, 32'h0);
    rst_n = 1'b1;

    // 1: fetch-only latency
    step();
    bus.if_req = 1; bus.if_addr = 32'h100;
    #1;
    check("t1_stall_t0", bus.stall_f, 1'b1);
    step();
    check("t1_mem_req_t1", bus.mem_req, 1'b1);
    check("t1_mem_addr", bus.mem_addr, 32'h100);
    check("t1_mem_we", bus.mem_we, 1'b0);
    check("t1_stall_t1", bus.stall_f, 1'b1);
    step();
    check("t1_mem_req_t2", bus.mem_req, 1'b0);
    check("t1_stall_t2", bus.stall_f, 1'b1);
    step();
    check("t1_valid_t3", bus.if_valid, 1'b0);
    check("t1_stall_t3", bus.stall_f, 1'b1);
    step();
    check("t1_valid_t4", bus.if_valid, 1'b1);
    check("t1_rdata", bus.if_rdata, 32'h0050_0093);
    check("t1_stall_t4", bus.stall_f, 1'b0);
    bus.if_req = 0;
    step();
    check("t1_valid_t5", bus.if_valid, 1'b0);

    // 2: simultaneous requests, data first
    grants.delete();
    f_issue = -1; dv_cyc = -100; done = 0;
    bus.if_req = 1; bus.if_addr = 32'h104;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h2000;
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      if (bus.mem_req && bus.mem_addr == 32'h104 && f_issue < 0) f_issue = cyc;
      if (bus.dm_valid) begin
        dv_cyc = cyc;
        check("t2_dm_rdata", bus.dm_rdata, 32'h5A5A_2000);
        check("t2_if_not_first", bus.if_valid, 1'b0);
        bus.dm_req = 0;
      end
      if (bus.if_valid) begin
        check("t2_if_rdata", bus.if_rdata, 32'h5A5A_0104);
        bus.if_req = 0;
        done = 1;
      end
    end
    check("t2_done", done, 1'b1);
    check("t2_fetch_issue_cyc", f_issue, dv_cyc + 1);
    check("t2_grant_cnt", grants.size(), 2);
    g = (grants.size() > 0) ? grants[0] : 32'hFFFF_FFFF;
    check("t2_grant0", g, 32'h2000);
    g = (grants.size() > 1) ? grants[1] : 32'hFFFF_FFFF;
    check("t2_grant1", g, 32'h104);

    // 3: streak fairness with both held
    step();
    grants.delete();
    exp_order = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h300, 32'h400};
    bus.if_req = 1; bus.if_addr = 32'h300;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h400;
    for (int i = 0; i < 80 && grants.size() < 6; i++) begin
      step();
      if (bus.mem_ready && grants.size() == 4)
        check("t3_streak_max", dut.u_streak.count_reg, 4'd4);
      if (bus.mem_ready && grants.size() == 5)
        check("t3_streak_clr", dut.u_streak.count_reg, 4'd0);
    end
    bus.if_req = 0; bus.dm_req = 0;
    check("t3_grant_cnt", grants.size(), 6);
    for (int i = 0; i < 6; i++) begin
      g = (grants.size() > i) ? grants[i] : 32'hFFFF_FFFF;
      check($sformatf("t3_order%0d", i), g, exp_order[i]);
    end
    wait_valid(1'b1, "t3_last_valid");
    step();
    check("t3_streak_idle", dut.u_streak.count_reg, 4'd0);

    // 4: write with delayed mem_ready
    ready_delay = 3;
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h2004; bus.dm_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t4_req%0d", i), bus.mem_req, 1'b1);
      check($sformatf("t4_addr%0d", i), bus.mem_addr, 32'h2004);
      check($sformatf("t4_wdata%0d", i), bus.mem_wdata, 32'hDEAD_BEEF);
      check($sformatf("t4_we%0d", i), bus.mem_we, 1'b1);
      check($sformatf("t4_stall%0d", i), bus.stall_m, 1'b1);
    end
    wait_valid(1'b1, "t4_valid");
    check("t4_rdata_kept", bus.dm_rdata, 32'h5A5A_0400);
    bus.dm_req = 0; bus.dm_we = 0;
    ready_delay = 0;
    step();

    // 5: reset during WAIT, stray rvalid afterwards
    mem_auto = 0;
    bus.mem_ready = 0; bus.mem_rvalid = 0;
    bus.dm_req = 1; bus.dm_addr = 32'h2008;
    step();
    check("t5_issue", bus.mem_req, 1'b1);
    bus.mem_ready = 1;
    step();
    bus.mem_ready = 0;
    check("t5_wait", bus.mem_req, 1'b0);
    rst_n = 0; bus.dm_req = 0;
    step();
    rst_n = 1;
    check("t5_req_after_rst", bus.mem_req, 1'b0);
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h1234_5678;
    step();
    bus.mem_rvalid = 0;
    check("t5_no_dm_valid0", bus.dm_valid, 1'b0);
    step();
    check("t5_no_dm_valid1", bus.dm_valid, 1'b0);
    check("t5_no_if_valid", bus.if_valid, 1'b0);
    check("t5_dm_rdata_rst", bus.dm_rdata, 32'h0);
    check("t5_idle_req", bus.mem_req, 1'b0);
    acc_pend = 0; wait_cnt = 0; mem_auto = 1;
    bus.if_req = 1; bus.if_addr = 32'h108;
    wait_valid(1'b0, "t5_after_valid");
    check("t5_after_rdata", bus.if_rdata, 32'h5A5A_0108);
    bus.if_req = 0;
    step();

    // 6: stray rvalid while idle
    mem_auto = 0;
    bus.mem_ready = 0;
    bus.mem_rvalid = 1; bus.mem_rdata = 32'hCAFE_F00D;
    step();
    bus.mem_rvalid = 0;
    check("t6_req0", bus.mem_req, 1'b0);
    step();
    check("t6_req1", bus.mem_req, 1'b0);
    check("t6_no_if_valid", bus.if_valid, 1'b0);
    check("t6_no_dm_valid", bus.dm_valid, 1'b0);
    check("t6_if_rdata", bus.if_rdata, 32'h5A5A_0108);
    check("t6_dm_rdata", bus.dm_rdata, 32'h0);
    acc_pend = 0; wait_cnt = 0; mem_auto = 1;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h3000;
    wait_valid(1'b1, "t6_next_valid");
    check("t6_next_rdata", bus.dm_rdata, 32'h5A5A_3000);
    bus.dm_req = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
